// File: rtl/dcm_reset_sequencer.sv
// Bring-up sequencer for the board DCM and game core: pulses DCM reset, retries on
// missing lock, and holds the core in reset until lock has been stable long enough.
module dcm_reset_sequencer #(
    parameter int unsigned DCM_RST_CYCLES = 3,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic       CLK_32MHZ,
    input  logic       RESET_N,
    input  logic       CLK_LOCKED,
    output logic       DCM_RST,
    output logic       CORE_RESET,
    output logic       LOCK_FAIL,
    output logic [3:0] RETRY_COUNT,
    output logic [2:0] STATE
);

    localparam int unsigned MAX_A = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int unsigned CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [2:0] S_DCM_RESET = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    localparam logic [CNT_W-1:0] DCM_LAST     = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic             sync_q;
    logic             locked_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       state_nxt;
    logic [3:0]       retry_nxt;

    // Two-flop synchronizer for the asynchronous DCM lock indication
    always_ff @(posedge CLK_32MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= CLK_LOCKED;
            locked_s <= sync_q;
        end
    end

    // State, shared counter, retry count and next-state-decoded outputs
    always_ff @(posedge CLK_32MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            STATE       <= S_DCM_RESET;
            cnt         <= '0;
            RETRY_COUNT <= 4'd0;
            DCM_RST     <= 1'b1;
            CORE_RESET  <= 1'b1;
            LOCK_FAIL   <= 1'b0;
        end else begin
            STATE       <= state_nxt;
            cnt         <= cnt_nxt;
            RETRY_COUNT <= retry_nxt;
            DCM_RST     <= (state_nxt == S_DCM_RESET);
            CORE_RESET  <= (state_nxt != S_RUN);
            LOCK_FAIL   <= (state_nxt == S_FAIL);
        end
    end

    // Next-state logic; lock takes priority over timeout, lock loss over release
    always_comb begin
        state_nxt = STATE;
        retry_nxt = RETRY_COUNT;
        cnt_nxt   = cnt;
        case (STATE)
            S_DCM_RESET: begin
                if (cnt == DCM_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (RETRY_COUNT == RETRY_LIMIT) begin
                        state_nxt = S_FAIL;
                    end else begin
                        retry_nxt = RETRY_COUNT + 4'd1;
                        state_nxt = S_DCM_RESET;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_nxt = S_DCM_RESET;
                    retry_nxt = 4'd0;
                end
            end
            S_FAIL: begin
                state_nxt = S_FAIL;
            end
            default: begin
                state_nxt = S_DCM_RESET;
                retry_nxt = 4'd0;
            end
        endcase

        if (state_nxt != STATE) begin
            cnt_nxt = '0;
        end else if ((STATE == S_RUN) || (STATE == S_FAIL)) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Directed bench for dcm_reset_sequencer with small parameters (3/16/8/2);
// edge numbers are counted from the first rising edge after RESET_N release.
module tb_dcm_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       clk_locked;
    logic       dcm_rst;
    logic       core_reset;
    logic       lock_fail;
    logic [3:0] retry_count;
    logic [2:0] state;
    logic [9:0] obs;

    int total = 0;
    int bad   = 0;

    dcm_reset_sequencer #(
        .DCM_RST_CYCLES(3),
        .LOCK_TIMEOUT  (16),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .CLK_32MHZ  (clk),
        .RESET_N    (rst_n),
        .CLK_LOCKED (clk_locked),
        .DCM_RST    (dcm_rst),
        .CORE_RESET (core_reset),
        .LOCK_FAIL  (lock_fail),
        .RETRY_COUNT(retry_count),
        .STATE      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {state, dcm_rst, core_reset, lock_fail, retry_count};

    function automatic logic [9:0] mk(input logic [2:0] st, input logic d, input logic c,
                                      input logic f, input logic [3:0] r);
        return {st, d, c, f, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lock);
        rst_n      = 1'b0;
        clk_locked = lock;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        rst_n      = 1'b0;
        clk_locked = 1'b0;
        repeat (3) tick();
        exp = mk(3'd0, 1'b1, 1'b1, 1'b0, 4'd0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_state: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_clean_bringup();
        logic [9:0] exp;
        logic [2:0] st;
        do_reset(1'b0);
        for (int e = 1; e <= 15; e++) begin
            tick();
            st  = (e < 3) ? 3'd0 : (e < 7) ? 3'd1 : (e < 15) ? 3'd2 : 3'd3;
            exp = mk(st, e < 3, e < 15, 1'b0, 4'd0);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL clean_bringup edge %0d: got %b expected %b", e, obs, exp);
            end
            if (e == 4) clk_locked = 1'b1;
        end
    endtask

    task automatic test_retry_then_lock();
        logic [9:0] exp;
        logic [2:0] st;
        do_reset(1'b0);
        for (int e = 1; e <= 33; e++) begin
            tick();
            st  = (e < 3) ? 3'd0 : (e < 19) ? 3'd1 : (e < 22) ? 3'd0 :
                  (e < 25) ? 3'd1 : (e < 33) ? 3'd2 : 3'd3;
            exp = mk(st, (e < 3) || (e >= 19 && e < 22), e < 33, 1'b0,
                     (e >= 19) ? 4'd1 : 4'd0);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL retry_then_lock edge %0d: got %b expected %b", e, obs, exp);
            end
            if (e == 22) clk_locked = 1'b1;
        end
    endtask

    task automatic test_give_up();
        logic [9:0] exp;
        logic [2:0] st;
        logic       prev;
        int         pulses;
        do_reset(1'b0);
        prev   = 1'b1;
        pulses = 1;
        for (int e = 1; e <= 57; e++) begin
            tick();
            st  = (e < 3) ? 3'd0 : (e < 19) ? 3'd1 : (e < 22) ? 3'd0 :
                  (e < 38) ? 3'd1 : (e < 41) ? 3'd0 : (e < 57) ? 3'd1 : 3'd4;
            exp = mk(st, (e < 3) || (e >= 19 && e < 22) || (e >= 38 && e < 41), 1'b1,
                     e == 57, (e < 19) ? 4'd0 : (e < 38) ? 4'd1 : 4'd2);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL give_up edge %0d: got %b expected %b", e, obs, exp);
            end
            if (dcm_rst && !prev) pulses++;
            prev = dcm_rst;
        end
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("FAIL give_up_pulses: got %0d expected 3", pulses);
        end
        clk_locked = 1'b1;
        exp = mk(3'd4, 1'b0, 1'b1, 1'b1, 4'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL fail_sticky cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp = mk(3'd0, 1'b1, 1'b1, 1'b0, 4'd0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL fail_cleared_by_reset: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_glitch_in_stable();
        logic [9:0] exp;
        logic [2:0] st;
        do_reset(1'b0);
        for (int e = 1; e <= 26; e++) begin
            tick();
            st  = (e < 3) ? 3'd0 : (e < 7) ? 3'd1 : (e < 15) ? 3'd2 :
                  (e < 18) ? 3'd1 : (e < 26) ? 3'd2 : 3'd3;
            exp = mk(st, e < 3, e < 26, 1'b0, 4'd0);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL glitch_in_stable edge %0d: got %b expected %b", e, obs, exp);
            end
            if (e == 4)  clk_locked = 1'b1;
            if (e == 12) clk_locked = 1'b0;
            if (e == 15) clk_locked = 1'b1;
        end
    endtask

    task automatic test_loss_in_run();
        logic [9:0] exp;
        logic [2:0] st;
        logic       cr;
        do_reset(1'b0);
        for (int e = 1; e <= 50; e++) begin
            tick();
            st  = (e < 3) ? 3'd0 : (e < 19) ? 3'd1 : (e < 22) ? 3'd0 : (e < 25) ? 3'd1 :
                  (e < 33) ? 3'd2 : (e < 38) ? 3'd3 : (e < 41) ? 3'd0 : (e < 42) ? 3'd1 :
                  (e < 50) ? 3'd2 : 3'd3;
            cr  = !((e >= 33 && e < 38) || e >= 50);
            exp = mk(st, (e < 3) || (e >= 19 && e < 22) || (e >= 38 && e < 41), cr, 1'b0,
                     (e >= 19 && e < 38) ? 4'd1 : 4'd0);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL loss_in_run edge %0d: got %b expected %b", e, obs, exp);
            end
            if (e == 22) clk_locked = 1'b1;
            if (e == 35) clk_locked = 1'b0;
            if (e == 39) clk_locked = 1'b1;
        end
    endtask

    task automatic test_async_reset_mid_stable();
        logic [9:0] exp;
        do_reset(1'b0);
        for (int e = 1; e <= 28; e++) begin
            tick();
            if (e == 22) clk_locked = 1'b1;
        end
        exp = mk(3'd2, 1'b0, 1'b1, 1'b0, 4'd1);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL pre_async_stable: got %b expected %b", obs, exp);
        end
        #3;
        rst_n = 1'b0;
        #1;
        exp = mk(3'd0, 1'b1, 1'b1, 1'b0, 4'd0);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL async_reset_mid_stable: got %b expected %b", obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        clk_locked = 1'b0;
        test_reset();
        test_clean_bringup();
        test_retry_then_lock();
        test_give_up();
        test_glitch_in_stable();
        test_loss_in_run();
        test_async_reset_mid_stable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcm_reset_sequencer.md
# dcm_reset_sequencer

Sequences bring-up of the board clock manager and the game core. Runs on the free-running board clock and pulses the DCM reset; it retries if lock never arrives and holds the core in reset until lock has been stable for a programmable time. It re-runs the sequence whenever lock is lost. It replaces the bare `!CLK_LOCKED` reset feed into the game core in the board top level.

## Interface
Parameters:
- DCM_RST_CYCLES, 3: cycles DCM_RST is held high per attempt (≥3 required by DCM); legal range 1..65535.
- LOCK_TIMEOUT, 65536: cycles spent waiting for lock before a retry; legal range 2..65536.
- STABLE_CYCLES, 1024: cycles lock must stay high before CORE_RESET releases; legal range 1..65536.
- MAX_RETRIES, 7: retries after the first attempt before giving up; legal range 0..15.

Ports:
- CLK_32MHZ  in  1  free-running board clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CLK_LOCKED  in  1  DCM LOCKED, asynchronous to CLK_32MHZ.
- DCM_RST  out  1  DCM reset, active high.
- CORE_RESET  out  1  game-core reset, active high.
- LOCK_FAIL  out  1  sticky retries-exhausted flag.
- RETRY_COUNT  out  4  retries issued in the current bring-up.
- STATE  out  3  current state code, for debug LEDs.

## Operation
- CLK_LOCKED passes through a 2-flop synchronizer (locked_s). Both flops reset to 0.
- One shared counter; width is clog2 of the largest parameter. It clears on every state entry.
- States and codes: DCM_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- All outputs are registered and decoded from next-state, so each output changes on the same edge as the state.
  - DCM_RST=1 only in DCM_RESET.
  - CORE_RESET=0 only in RUN.
  - LOCK_FAIL=1 only in FAIL.
- Reset values: STATE=DCM_RESET, DCM_RST=1, CORE_RESET=1, LOCK_FAIL=0, RETRY_COUNT=0, counter=0.
- DCM_RESET: after DCM_RST_CYCLES cycles in this state -> WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1 -> STABLE.
  - Otherwise the counter increments. At counter=LOCK_TIMEOUT-1 with no lock:
    - if RETRY_COUNT=MAX_RETRIES -> FAIL;
    - else RETRY_COUNT+1 and -> DCM_RESET.
  - Lock wins over timeout when both occur on the same cycle.
- STABLE:
  - locked_s=0 -> WAIT_LOCK. The timeout restarts; no retry is charged; DCM_RST is not re-pulsed.
  - At counter=STABLE_CYCLES-1 with locked_s=1 -> RUN.
- RUN:
  - locked_s=0 -> DCM_RESET; RETRY_COUNT clears to 0 (fresh bring-up).
  - CORE_RESET reasserts on that same edge.
- FAIL: terminal until RESET_N asserts.
  - DCM_RST=0, CORE_RESET=1.
  - locked_s is ignored.
- MAX_RETRIES=0: the first timeout goes straight to FAIL.

## Timing
- RESET_N assertion forces all reset values immediately, mid-operation included. Synchronizer flops also clear.
- After RESET_N deassertion, DCM_RST stays high for exactly DCM_RST_CYCLES rising edges.
- Every WAIT_LOCK timeout spans exactly LOCK_TIMEOUT cycles. A full failed attempt is DCM_RST_CYCLES+LOCK_TIMEOUT cycles.
- Lock acquire: CLK_LOCKED first sampled high at edge k -> STABLE at k+2 -> CORE_RESET falls at edge k+2+STABLE_CYCLES.
- Lock loss in RUN: CLK_LOCKED first sampled low at edge k -> CORE_RESET=1 and DCM_RST=1 at edge k+2.
- A lock glitch shorter than 1 cycle may be missed by the synchronizer. A glitch longer than 2 cycles is always seen.
- A glitch in STABLE delays release by at least STABLE_CYCLES from the re-lock.

## Test plan
Parameters for all scenarios: DCM_RST_CYCLES=3, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Clean bring-up: release RESET_N, raise CLK_LOCKED 5 cycles later and hold -> DCM_RST high 3 cycles; CORE_RESET falls exactly 10 edges after CLK_LOCKED is first sampled high; STATE=3; RETRY_COUNT=0.
2. Retry then lock: keep CLK_LOCKED low through one timeout, then raise it -> DCM_RST re-pulses for 3 cycles after 16 WAIT_LOCK cycles; RETRY_COUNT=1; bring-up then completes as in scenario 1.
3. Give-up: CLK_LOCKED never high -> three DCM_RST pulses; RETRY_COUNT=2; FAIL at edge 3+16+3+16+3+16=57 after reset release; LOCK_FAIL=1, DCM_RST=0, CORE_RESET=1 held. Raising CLK_LOCKED has no effect; RESET_N pulse -> LOCK_FAIL=0.
4. Glitch in STABLE: drop CLK_LOCKED for 3 cycles at STABLE count 5 -> STATE back to 1 with no DCM_RST pulse; CORE_RESET falls 10 edges after re-lock is first sampled.
5. Loss in RUN: drop CLK_LOCKED for 4 cycles while in RUN -> CORE_RESET=1 and DCM_RST=1 two edges after the drop; RETRY_COUNT=0; full re-sequence follows.
6. Async reset mid-STABLE: assert RESET_N between clock edges -> all outputs at reset values before the next edge.
